// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle for rv32m_muldiv_unit: the requester drives the master side,
// the unit implements the slave side.
interface rv32m_muldiv_if #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 32
);
  logic               ena;
  logic               start;
  logic [2:0]         op;
  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;
  logic               busy;
  logic               done;
  logic [XLEN-1:0]    result;
  logic [COUNT_W-1:0] ops_completed;

  modport master (
    output ena, start, op, a, b,
    input  busy, done, result, ops_completed
  );

  modport slave (
    input  ena, start, op, a, b,
    output busy, done, result, ops_completed
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on magnitudes.
// Define RV32M_MULDIV_FAST_SPECIAL_EN to finish trivial cases (x/0, overflow, zero multiply) in one cycle.
module rv32m_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  rv32m_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg, op_next;
  logic               neg_reg, neg_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [XLEN-1:0]    hi_reg, hi_next;
  logic [XLEN-1:0]    lo_reg, lo_next;
  logic [XLEN-1:0]    dsr_reg, dsr_next;
  logic [XLEN-1:0]    result_reg, result_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  // Request decode: operand signedness, magnitudes and the final sign fix-up.
  logic            a_signed, b_signed, a_neg, b_neg, req_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign a_neg    = a_signed && bus.a[XLEN-1];
  assign b_neg    = b_signed && bus.b[XLEN-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;
  // A zero divisor must leave the all-ones quotient unsigned; remainder follows the dividend.
  assign req_neg  = bus.op[2] ? (bus.op[1] ? a_neg : ((bus.b != '0) && (a_neg ^ b_neg)))
                              : (a_neg ^ b_neg);

  // One radix-2 step; hi/lo hold {product} for multiply and {remainder, quotient} for divide.
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, step_hi, step_lo, calc_result;
  logic [2*XLEN-1:0] prod_fix;

  assign mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dsr_reg} : {(XLEN+1){1'b0}});
  assign rem_sh   = {hi_reg, lo_reg[XLEN-1]};
  assign div_ge   = rem_sh >= {1'b0, dsr_reg};
  assign div_diff = rem_sh[XLEN-1:0] - dsr_reg;
  assign step_hi  = op_reg[2] ? (div_ge ? div_diff : rem_sh[XLEN-1:0]) : mul_sum[XLEN:1];
  assign step_lo  = op_reg[2] ? {lo_reg[XLEN-2:0], div_ge} : {mul_sum[0], lo_reg[XLEN-1:1]};
  assign prod_fix = neg_reg ? -{step_hi, step_lo} : {step_hi, step_lo};

  always_comb begin
    calc_result = '0;
    case (op_reg)
      3'd0:                calc_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    calc_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          calc_result = neg_reg ? -step_lo : step_lo;
      default:             calc_result = neg_reg ? -step_hi : step_hi;
    endcase
  end

`ifdef RV32M_MULDIV_FAST_SPECIAL_EN
  logic            req_ovf, req_special;
  logic [XLEN-1:0] fast_result;

  assign req_ovf     = b_signed && bus.op[2] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
  assign req_special = bus.op[2] ? ((bus.b == '0) || req_ovf) : ((bus.a == '0) || (bus.b == '0));
  assign fast_result = !bus.op[2]      ? '0 :
                       (bus.b == '0)   ? (bus.op[1] ? bus.a : '1) :
                                         (bus.op[1] ? '0 : bus.a);
`endif

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    neg_next    = neg_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    dsr_next    = dsr_reg;
    result_next = result_reg;
    count_next  = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          op_next    = bus.op;
          neg_next   = req_neg;
          cnt_next   = '0;
          hi_next    = '0;
          lo_next    = bus.op[2] ? a_mag : b_mag;
          dsr_next   = bus.op[2] ? b_mag : a_mag;
          state_next = S_CALC;
`ifdef RV32M_MULDIV_FAST_SPECIAL_EN
          if (req_special) begin
            state_next  = S_DONE;
            result_next = fast_result;
            count_next  = count_reg + 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        hi_next  = step_hi;
        lo_next  = step_lo;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          state_next  = S_DONE;
          result_next = calc_result;
          count_next  = count_reg + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      dsr_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else if (bus.ena) begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      neg_reg    <= neg_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      dsr_reg    <= dsr_next;
      result_reg <= result_next;
      count_reg  <= count_next;
    end
  end

  assign bus.busy          = (state_reg == S_CALC);
  assign bus.done          = (state_reg == S_DONE);
  assign bus.result        = result_reg;
  assign bus.ops_completed = count_reg;
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit (XLEN=32): directed vector table, randomized ops
// against an arithmetic reference model, and hand sequences for ena stalls and mid-operation reset.
module tb_rv32m_muldiv_unit;
  localparam int XLEN = 32;
`ifdef RV32M_MULDIV_FAST_SPECIAL_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = XLEN + 1;
`endif
  localparam int FULL_LAT = XLEN + 1;

  logic clk;
  logic rst;
  rv32m_muldiv_if #(.XLEN(XLEN), .COUNT_W(32)) bus ();

  rv32m_muldiv_unit #(.XLEN(XLEN), .COUNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_ops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: RISC-V M-extension semantics in 64-bit integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  // Issue one op from an idle negedge; returns result and ops count at done, latency in cycles
  // after the accepting edge, busy cycles seen, and done one cycle later.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic [31:0] ops_at_done, output logic done_after);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      bus.op = 3'($urandom_range(0, 7)); bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    ops_at_done = bus.ops_completed;
    @(negedge clk);
    done_after = bus.done;
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d busy=%0d", op, a, b, res, lat, bcnt);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, ops_d, r_exp, snap;
    logic        done_after;
    int          lat, bcnt, elat, ndone;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1'b1};
    vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[10] = '{3'd1, 32'd0,          32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[11] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1};
    vecs[13] = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};

    rst = 1'b0; bus.ena = 1'b0; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset ops_completed", 64'(bus.ops_completed), 64'd0);
    rst = 1'b1; bus.ena = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, ops_d, done_after);
      exp_ops++;
      elat = vecs[i].special ? FAST_LAT : FULL_LAT;
      check($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(elat));
      check($sformatf("vec%0d busy cycles", i), 64'(bcnt), 64'(elat - 1));
      check($sformatf("vec%0d done one cycle", i), 64'(done_after), 64'd0);
      check($sformatf("vec%0d ops_completed", i), 64'(ops_d), 64'(exp_ops));
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, res, lat, bcnt, ops_d, done_after);
      exp_ops++;
      elat = is_special(rop, ra, rb) ? FAST_LAT : FULL_LAT;
      check($sformatf("rand%0d result", i), 64'(res), 64'(ref_op(rop, ra, rb)));
      check($sformatf("rand%0d latency", i), 64'(lat), 64'(elat));
      check($sformatf("rand%0d ops_completed", i), 64'(ops_d), 64'(exp_ops));
    end

    // ena low for 10 cycles mid-operation, plus a start pulse while busy that must be dropped.
    r_exp = ref_op(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
    snap  = bus.result;
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1357_9BDF;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      bus.ena   = !(lat >= 5 && lat < 15);
      bus.start = (lat == 20);
      bus.a = $urandom; bus.b = $urandom;
      if (lat == 10) check("stall result held", 64'(bus.result), 64'(snap));
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0; bus.ena = 1'b1;
    exp_ops++;
    check("stall latency", 64'(lat), 64'(FULL_LAT + 10));
    check("stall result", 64'(bus.result), 64'(r_exp));
    check("stall ops_completed", 64'(bus.ops_completed), 64'(exp_ops));
    $display("op=1 a=0xdeadbeef b=0x13579bdf result=0x%08h latency=%0d (ena stall)", bus.result, lat);
    bus.ena = 1'b0;
    repeat (3) @(negedge clk);
    check("done held while ena low", 64'(bus.done), 64'd1);
    check("ops held while ena low", 64'(bus.ops_completed), 64'(exp_ops));
    bus.ena = 1'b1;
    @(negedge clk);
    check("done drops after ena", 64'(bus.done), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("busy start not queued", 64'(ndone), 64'd0);
    check("ops after ignored start", 64'(bus.ops_completed), 64'(exp_ops));

    // Reset in the middle of a divide abandons it.
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hCAFE_F00D; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset busy", 64'(bus.busy), 64'd0);
    check("midreset done", 64'(bus.done), 64'd0);
    check("midreset result", 64'(bus.result), 64'd0);
    check("midreset ops_completed", 64'(bus.ops_completed), 64'd0);
    rst = 1'b1;
    exp_ops = 0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no done after reset", 64'(ndone), 64'd0);
    check("ops zero after reset", 64'(bus.ops_completed), 64'd0);

    run_op(vecs[0].op, vecs[0].a, vecs[0].b, res, lat, bcnt, ops_d, done_after);
    exp_ops++;
    check("post-reset result", 64'(res), 64'(vecs[0].exp));
    check("post-reset latency", 64'(lat), 64'(FULL_LAT));
    check("post-reset ops_completed", 64'(ops_d), 64'(exp_ops));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rv32m_muldiv_unit.md
RV32M_MULDIV_UNIT -- requirements
Module: rv32m_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter COUNT_W, default 32, width of ops_completed.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port start  input  1  request; sampled only in S_IDLE with ena high.
REQ-007 SHALL have port op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have port a  input  XLEN  rs1 operand, captured on accepted start.
REQ-009 SHALL have port b  input  XLEN  rs2 operand, captured on accepted start.
REQ-010 SHALL have port busy  output  1  high while in S_CALC.
REQ-011 SHALL have port done  output  1  high exactly one cycle, in S_DONE.
REQ-012 SHALL have port result  output  XLEN  last completed result, held until next done.
REQ-013 SHALL have port ops_completed  output  COUNT_W  count of done pulses, wraps to 0.

Function
REQ-014 SHALL implement FSM states S_IDLE, S_CALC, S_DONE.
REQ-015 S_IDLE: start=1 and ena=1 -> latch op/a/b, iteration counter=0, go S_CALC; otherwise stay.
REQ-016 S_CALC: one radix-2 step per enabled cycle (shift-add multiply over 2*XLEN product; restoring divide on magnitudes); after XLEN steps go S_DONE.
REQ-017 S_DONE: done=1, result updated same edge S_DONE entered, ops_completed increments by 1; next enabled cycle go S_IDLE.
REQ-018 Normal latency: done asserts XLEN+1 cycles after the start-accepting edge (no ena stalls).
REQ-019 MUL returns low XLEN of product; MULH/MULHSU/MULHU return high XLEN with signed*signed, signed*unsigned, unsigned*unsigned operand interpretation.
REQ-020 DIV/REM: signed, quotient truncates toward zero, remainder takes sign of dividend.
REQ-021 Divide by zero: DIV/DIVU quotient all ones; REM/REMU remainder = a.
REQ-022 Signed overflow (a = most-negative, b = all ones): DIV returns a; REM returns 0.
REQ-023 start while in S_CALC or S_DONE SHALL be ignored; no queueing.
REQ-024 Input changes on a/b/op after acceptance SHALL not affect the in-flight operation.
REQ-025 ena=0: FSM, counter, datapath, result, ops_completed hold; done stays at current value until ena returns.
REQ-026 ops_completed at all ones SHALL wrap to 0 on next done.

Reset
REQ-027 rst=0 at a rising edge SHALL force S_IDLE, busy=0, done=0, result=0, ops_completed=0, regardless of ena.
REQ-028 Reset mid-S_CALC SHALL abandon the operation without a done pulse or count increment.
REQ-029 First start SHALL be accepted on the first edge with rst=1, ena=1, start=1.

Configuration
REQ-030 Macro RV32M_MULDIV_FAST_SPECIAL_EN, when defined, SHALL route divide-by-zero, signed overflow, and any multiply with a zero operand from S_IDLE directly to S_DONE, done one cycle after acceptance.
REQ-031 Without RV32M_MULDIV_FAST_SPECIAL_EN, those cases SHALL take full XLEN+1 latency; results SHALL be bit-identical in both builds.

Verification (XLEN=32)
REQ-032 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done 33 cycles after accept, busy high 32 cycles, ops_completed 1.
REQ-033 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, REM -> 0; done after 1 cycle with macro, 33 without.
REQ-036 ena low for 10 cycles mid-S_CALC -> done at 43 cycles, correct result; start pulsed during busy ignored.
REQ-037 rst low at cycle 10 of S_CALC -> next cycle busy=0, done=0, result=0, ops_completed=0; no done pulse follows.
